// File: rtl/io_handshake_unit.sv
// io_handshake_unit: user-side responder for core INPUT/OUTPUT/PAUSE requests.
// Debounces the key, captures switches, latches display data, pulses acks.
module io_handshake_unit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SWITCH_WIDTH    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    is_input,
    input  logic                    is_output,
    input  logic [31:0]             core_output_data,
    input  logic                    button_raw,
    input  logic [SWITCH_WIDTH-1:0] switches,
    output logic                    confirmation,
    output logic                    continue_button,
    output logic [31:0]             input_data,
    output logic [31:0]             display_data,
    output logic                    waiting
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        ACK,
        WAIT_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        K_INPUT,
        K_OUTPUT,
        K_PAUSE
    } kind_t;

    logic                    btn_meta;
    logic                    btn_sync;
    logic                    btn_level;
    logic                    btn_level_q;
    logic [CW-1:0]           db_cnt;
    logic [SWITCH_WIDTH-1:0] sw_q;

    state_t state;
    state_t state_nx;
    kind_t  kind;
    kind_t  kind_nx;

    logic any_req;
    logic press;
    logic cap_display;
    logic cap_input;

    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            sw_q     <= '0;
        end else begin
            btn_meta <= button_raw;
            btn_sync <= btn_meta;
            sw_q     <= switches;
        end
    end

    // A level change is accepted only after an unbroken mismatch run.
    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_level <= 1'b0;
            db_cnt    <= '0;
        end else if (btn_sync == btn_level) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_TOP) begin
            btn_level <= btn_sync;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_level_q <= 1'b0;
        end else begin
            btn_level_q <= btn_level;
        end
    end

    assign press   = btn_level & ~btn_level_q;
    assign any_req = is_input | is_output;

    always_comb begin
        kind_nx = K_OUTPUT;
        unique case (1'b1)
            is_input && is_output:  kind_nx = K_PAUSE;
            is_input && !is_output: kind_nx = K_INPUT;
            default:                kind_nx = K_OUTPUT;
        endcase
    end

    always_comb begin
        state_nx    = state;
        cap_display = 1'b0;
        cap_input   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx    = WAIT_PRESS;
                    cap_display = (kind_nx == K_OUTPUT);
                end
            end
            WAIT_PRESS: begin
                if (!any_req) begin
                    state_nx = IDLE;
                end else if (press) begin
                    state_nx  = ACK;
                    cap_input = (kind == K_INPUT);
                end
            end
            ACK: begin
                state_nx = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!btn_level) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            kind  <= K_INPUT;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                kind <= kind_nx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            display_data <= '0;
            input_data   <= '0;
        end else begin
            if (cap_display) begin
                display_data <= core_output_data;
            end
            if (cap_input) begin
                input_data <= 32'(sw_q);
            end
        end
    end

    assign confirmation    = (state == ACK) && (kind != K_PAUSE);
    assign continue_button = (state == ACK) && (kind == K_PAUSE);
    assign waiting         = (state == WAIT_PRESS);

endmodule

// File: tb/tb_io_handshake_unit.sv
// tb_io_handshake_unit: directed and randomized handshakes against
// a transaction-level expectation of acks, latency and captured data.
module tb_io_handshake_unit;

    localparam int D   = 4;
    localparam int SW  = 16;
    localparam int LAT = 2 + D + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          is_input;
    logic          is_output;
    logic [31:0]   core_output_data;
    logic          button_raw;
    logic [SW-1:0] switches;
    logic          confirmation;
    logic          continue_button;
    logic [31:0]   input_data;
    logic [31:0]   display_data;
    logic          waiting;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_conf;
    int n_cont;
    int ack_cyc;
    int rise;
    logic [31:0] in_at_ack;
    logic [31:0] exp_display = '0;
    logic [31:0] exp_input   = '0;

    io_handshake_unit #(
        .DEBOUNCE_CYCLES(D),
        .SWITCH_WIDTH(SW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .is_input(is_input),
        .is_output(is_output),
        .core_output_data(core_output_data),
        .button_raw(button_raw),
        .switches(switches),
        .confirmation(confirmation),
        .continue_button(continue_button),
        .input_data(input_data),
        .display_data(display_data),
        .waiting(waiting)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle; behaves like the core: drops requests on an ack.
    task automatic step();
        @(negedge clock);
        if (confirmation) n_conf++;
        if (continue_button) n_cont++;
        if (confirmation || continue_button) begin
            if (ack_cyc < 0) begin
                ack_cyc   = cyc;
                in_at_ack = input_data;
            end
            is_input  = 1'b0;
            is_output = 1'b0;
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clr();
        n_conf  = 0;
        n_cont  = 0;
        ack_cyc = -1;
    endtask

    task automatic request(input bit i, input bit o,
                           input logic [31:0] d);
        is_input         = i;
        is_output        = o;
        core_output_data = d;
        if (o && !i) exp_display = d;
        step();
        chk("req_waiting", 32'(waiting), 32'd1);
        chk("req_display", display_data, exp_display);
    endtask

    task automatic clean_hs(input bit i, input bit o,
                            input logic [31:0] d,
                            input logic [SW-1:0] sw,
                            input int hold);
        bit pause;
        pause    = i && o;
        switches = sw;
        clr();
        request(i, o, d);
        if (i && !o) exp_input = 32'(sw);
        rise       = cyc;
        button_raw = 1'b1;
        steps(hold);
        button_raw = 1'b0;
        steps(D + 6);
        chk("hs_conf_cnt", 32'(n_conf), pause ? 32'd0 : 32'd1);
        chk("hs_cont_cnt", 32'(n_cont), pause ? 32'd1 : 32'd0);
        chk("hs_latency", 32'(ack_cyc - rise), 32'(LAT));
        chk("hs_input", input_data, exp_input);
        chk("hs_display", display_data, exp_display);
        chk("hs_idle_wait", 32'(waiting), 32'd0);
        if (i && !o) chk("hs_in_at_ack", in_at_ack, exp_input);
    endtask

    task automatic withdraw_hs(input bit i, input bit o,
                               input logic [31:0] d,
                               input logic [SW-1:0] sw);
        switches = sw;
        clr();
        request(i, o, d);
        steps($urandom_range(1, 4));
        is_input  = 1'b0;
        is_output = 1'b0;
        step();
        chk("wd_waiting", 32'(waiting), 32'd0);
        button_raw = 1'b1;
        steps(LAT + 3);
        button_raw = 1'b0;
        steps(D + 6);
        chk("wd_acks", 32'(n_conf + n_cont), 32'd0);
        chk("wd_display", display_data, exp_display);
        chk("wd_input", input_data, exp_input);
    endtask

    initial begin
        int k;
        reset            = 1'b0;
        is_input         = 1'b0;
        is_output        = 1'b0;
        core_output_data = '0;
        button_raw       = 1'b0;
        switches         = '0;
        clr();

        steps(3);
        chk("rst_conf", 32'(confirmation), 32'd0);
        chk("rst_cont", 32'(continue_button), 32'd0);
        chk("rst_wait", 32'(waiting), 32'd0);
        chk("rst_input", input_data, 32'd0);
        chk("rst_display", display_data, 32'd0);
        reset = 1'b1;
        step();
        chk("post_rst_wait", 32'(waiting), 32'd0);

        clean_hs(1'b0, 1'b1, 32'hCAFE_0042, 16'h1234, 10);
        clean_hs(1'b1, 1'b0, 32'h0, 16'hA5F0, 10);
        clean_hs(1'b1, 1'b1, 32'hDEAD_BEEF, 16'h5555, 10);

        // bouncing press, then a request raised while still held
        switches = 16'h3C3C;
        clr();
        request(1'b1, 1'b0, 32'h0);
        for (int t = 0; t < 20; t++) begin
            button_raw = ~button_raw;
            step();
        end
        button_raw = 1'b1;
        steps(12);
        exp_input = 32'h0000_3C3C;
        chk("bnc_conf_cnt", 32'(n_conf), 32'd1);
        chk("bnc_input", input_data, exp_input);
        is_input = 1'b1;
        clr();
        steps(15);
        chk("held_no_ack", 32'(n_conf), 32'd0);
        chk("held_wait", 32'(waiting), 32'd0);
        button_raw = 1'b0;
        steps(15);
        chk("rel_no_ack", 32'(n_conf), 32'd0);
        chk("rel_wait", 32'(waiting), 32'd1);
        switches   = 16'h0F0F;
        rise       = cyc;
        button_raw = 1'b1;
        steps(12);
        button_raw = 1'b0;
        steps(D + 6);
        exp_input = 32'h0000_0F0F;
        chk("fresh_conf_cnt", 32'(n_conf), 32'd1);
        chk("fresh_latency", 32'(ack_cyc - rise), 32'(LAT));
        chk("fresh_input", input_data, exp_input);

        withdraw_hs(1'b0, 1'b1, 32'h1111_2222, 16'h0001);

        for (int n = 0; n < 12; n++) begin
            k = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0)
                withdraw_hs(k[0], k[1], $urandom, SW'($urandom));
            else
                clean_hs(k[0], k[1], $urandom, SW'($urandom),
                         $urandom_range(LAT + 2, LAT + 8));
        end

        // reset in the middle of the debounce count
        switches = 16'h7777;
        clr();
        request(1'b1, 1'b0, 32'h0);
        button_raw = 1'b1;
        steps(3);
        reset      = 1'b0;
        is_input   = 1'b0;
        button_raw = 1'b0;
        steps(2);
        chk("mid_rst_conf", 32'(confirmation), 32'd0);
        chk("mid_rst_cont", 32'(continue_button), 32'd0);
        chk("mid_rst_wait", 32'(waiting), 32'd0);
        chk("mid_rst_input", input_data, 32'd0);
        chk("mid_rst_display", display_data, 32'd0);
        reset = 1'b1;
        steps(15);
        chk("mid_rst_acks", 32'(n_conf + n_cont), 32'd0);
        chk("mid_rst_idle", 32'(waiting), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
